uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1 transmitter in the DUART channel datapath.
- Supports 5–8 data bits, none/even/odd/force-1 parity, and 1 or 2 stop bits.
- A one-entry holding register lets the host load the next character during the current frame, giving gap-free back-to-back frames.
- Sits between the channel register interface (THR write, mode register fields) and the TxD pin.

Parameters:
- CLKS_PER_BIT, 417: i_Clock cycles per bit period; legal range ≥2. Counter width is $clog2(CLKS_PER_BIT)+1.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_TX_DV  input  1  write strobe; accepted only when o_TX_Ready=1, otherwise ignored.
- i_TX_Byte  input  8  character; only the low N bits are used (N = data bits).
- i_Data_Bits  input  2  00=5, 01=6, 10=7, 11=8 data bits.
- i_Parity_Mode  input  2  00=none, 01=even, 10=odd, 11=force-1 (parity bit always 1).
- i_Stop_Bits  input  1  0=one stop bit, 1=two stop bits.
- o_TX_Ready  output  1  holding register empty (TxRDY).
- o_TX_Empty  output  1  holding empty and shifter idle (TxEMT).
- o_TX_Active  output  1  a frame is on the line (start bit through final stop bit).
- o_TX_Serial  output  1  TxD; idles high.
- o_TX_Done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, o_TX_Empty=1.
  - Holding register and shifter are discarded; counters clear; FSM goes to IDLE.
- Holding register:
  - On an edge with i_TX_DV=1 and o_TX_Ready=1, capture i_TX_Byte; o_TX_Ready falls after that edge.
  - A DV while full is dropped with no state change.
  - o_TX_Ready rises on the edge the shifter loads from the holding register.
  - DV on the same edge as that load, while still full, is ignored.
- Configuration: i_Data_Bits, i_Parity_Mode and i_Stop_Bits are sampled only on the shifter-load edge and held for the whole frame. Changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_TX_Serial=1. If holding is full → load shifter, latch config, compute parity, drive o_TX_Serial=0, go to START. First start-bit clock is the edge after the accept edge (latency 1).
  - START: low for exactly CLKS_PER_BIT clocks → DATA, bit index 0.
  - DATA: LSB first; each bit lasts CLKS_PER_BIT clocks. After bit N-1 → PARITY if parity enabled, else STOP.
  - PARITY: one bit period.
    - Even: XOR of the N used bits.
    - Odd: inverse of that XOR.
    - Force-1: 1.
    - Unused upper bits never contribute.
  - STOP: high for CLKS_PER_BIT × (1 or 2) clocks. On the final clock edge, pulse o_TX_Done for 1 cycle and then:
    - if holding is full: load it and go straight to START, with no idle clock between frames; o_TX_Active stays 1;
    - else: go to IDLE; o_TX_Active falls.
- Frame length is exactly (1 + N + P + S) × CLKS_PER_BIT clocks, where P∈{0,1} and S∈{1,2}.
- Bit counter wraps to 0 at each bit boundary. The data index is 3 bits, compared against N-1.
- o_TX_Empty = o_TX_Ready & ~o_TX_Active.
- Illegal FSM encodings → IDLE.

Test Plan:
- CLKS_PER_BIT=4, 8 bits/no parity/1 stop, send 0xA5:
  - TxD pattern 0,1,0,1,0,0,1,0,1,1, 4 clocks each (40 clocks).
  - o_TX_Done pulses once at clock 40; o_TX_Empty returns to 1.
- 7 bits/even/1 stop, send 0xFF:
  - 7 data bits of 1, parity bit 1 (odd count of 7 ones → parity 1); bit 7 is ignored.
  - 7 bits/odd: parity bit 0.
  - 5 bits/force-1, send 0x00: parity bit 1.
- Two stop bits, 6 bits, send 0x15: stop high 8 clocks; total frame 36 clocks.
- Back-to-back: write 0x55, then write 0x33 during the first frame's data bits.
  - o_TX_Ready=0 until the second load.
  - Second start bit immediately follows the first stop bit with no idle clock.
  - Exactly two Done pulses.
- A third write while holding is full is dropped: only two frames appear on the line.
- Change i_Data_Bits from 8→5 mid-frame: current frame keeps 8 bits; the next frame uses 5.
- Assert i_Rst_L=0 during DATA:
  - o_TX_Serial=1 and o_TX_Active=0 immediately, o_TX_Ready=1.
  - After release the line stays idle until a new DV.

Source files
------------

// File: rtl/uart_tx_cfg_if.sv
// Host-side bundle for the configurable UART transmitter: THR write strobe,
// character, mode fields, and the status/line outputs.
interface uart_tx_cfg_if;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic [1:0] i_Data_Bits;
  logic [1:0] i_Parity_Mode;
  logic       i_Stop_Bits;
  logic       o_TX_Ready;
  logic       o_TX_Empty;
  logic       o_TX_Active;
  logic       o_TX_Serial;
  logic       o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte, i_Data_Bits, i_Parity_Mode, i_Stop_Bits,
    input  o_TX_Ready, o_TX_Empty, o_TX_Active, o_TX_Serial, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte, i_Data_Bits, i_Parity_Mode, i_Stop_Bits,
    output o_TX_Ready, o_TX_Empty, o_TX_Active, o_TX_Serial, o_TX_Done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, none/even/odd/force-1
// parity, 1 or 2 stop bits) with a one-entry holding register so the host can
// queue the next character and frames run back to back without idle clocks.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 417
) (
  input  logic           i_Clock,
  input  logic           i_Rst_L,
  uart_tx_cfg_if.slave   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Mask selecting the data bits actually sent for a given word length.
  function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
    logic [7:0] m;
    case (data_bits)
      2'b00:   m = 8'h1F;
      2'b01:   m = 8'h3F;
      2'b10:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Parity bit for the used data bits; unused upper bits are masked off.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] data_bits,
                                      input logic [1:0] mode);
    logic x;
    logic p;
    x = ^(data & data_mask(data_bits));
    case (mode)
      2'b01:   p = x;
      2'b10:   p = ~x;
      2'b11:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  state_t           state_r,       state_s;
  logic [CNT_W-1:0] cnt_r,         cnt_s;
  logic [2:0]       idx_r,         idx_s;
  logic [2:0]       last_idx_r,    last_idx_s;
  logic [7:0]       shift_r,       shift_s;
  logic             par_en_r,      par_en_s;
  logic             par_bit_r,     par_bit_s;
  logic             stop2_r,       stop2_s;
  logic             stop_second_r, stop_second_s;
  logic [7:0]       hold_r,        hold_s;
  logic             hold_full_r,   hold_full_s;
  logic             serial_r,      serial_s;
  logic             active_r,      active_s;
  logic             done_r,        done_s;
  logic             bit_end_s;
  logic             load_s;

  assign bus.o_TX_Serial = serial_r;
  assign bus.o_TX_Active = active_r;
  assign bus.o_TX_Done   = done_r;
  assign bus.o_TX_Ready  = ~hold_full_r;
  assign bus.o_TX_Empty  = ~hold_full_r & ~active_r;

  // Next-state, datapath and output logic for the frame sequencer.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    idx_s         = idx_r;
    last_idx_s    = last_idx_r;
    shift_s       = shift_r;
    par_en_s      = par_en_r;
    par_bit_s     = par_bit_r;
    stop2_s       = stop2_r;
    stop_second_s = stop_second_r;
    hold_s        = hold_r;
    hold_full_s   = hold_full_r;
    serial_s      = serial_r;
    active_s      = active_r;
    done_s        = 1'b0;
    load_s        = 1'b0;
    bit_end_s     = (cnt_r == CNT_LAST);

    case (state_r)
      IDLE: begin
        serial_s = 1'b1;
        active_s = 1'b0;
        cnt_s    = {CNT_W{1'b0}};
        if (hold_full_r) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_s    = {CNT_W{1'b0}};
          idx_s    = 3'd0;
          serial_s = shift_r[0];
          state_s  = DATA;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s = {CNT_W{1'b0}};
          if (idx_r == last_idx_r) begin
            if (par_en_r) begin
              serial_s = par_bit_r;
              state_s  = PARITY;
            end else begin
              serial_s      = 1'b1;
              stop_second_s = 1'b0;
              state_s       = STOP;
            end
          end else begin
            idx_s    = idx_r + 3'd1;
            shift_s  = {1'b0, shift_r[7:1]};
            serial_s = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          cnt_s         = {CNT_W{1'b0}};
          serial_s      = 1'b1;
          stop_second_s = 1'b0;
          state_s       = STOP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_s = {CNT_W{1'b0}};
          if (stop2_r && !stop_second_r) begin
            stop_second_s = 1'b1;
          end else begin
            done_s = 1'b1;
            if (hold_full_r) begin
              load_s = 1'b1;
            end else begin
              serial_s = 1'b1;
              active_s = 1'b0;
              state_s  = IDLE;
            end
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s  = IDLE;
        cnt_s    = {CNT_W{1'b0}};
        serial_s = 1'b1;
        active_s = 1'b0;
      end
    endcase

    // Shifter load takes the held character and freezes the frame format;
    // a write on this edge is ignored because the holding register is still full.
    if (load_s) begin
      shift_s       = hold_r;
      last_idx_s    = {1'b0, bus.i_Data_Bits} + 3'd4;
      par_en_s      = (bus.i_Parity_Mode != 2'b00);
      par_bit_s     = parity_bit(hold_r, bus.i_Data_Bits, bus.i_Parity_Mode);
      stop2_s       = bus.i_Stop_Bits;
      stop_second_s = 1'b0;
      idx_s         = 3'd0;
      cnt_s         = {CNT_W{1'b0}};
      serial_s      = 1'b0;
      active_s      = 1'b1;
      hold_full_s   = 1'b0;
      state_s       = START;
    end else if (bus.i_TX_DV && !hold_full_r) begin
      hold_s      = bus.i_TX_Byte;
      hold_full_s = 1'b1;
    end else begin
      hold_full_s = hold_full_r;
    end
  end

  // State and datapath registers; reset discards any frame and held character.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      idx_r         <= 3'd0;
      last_idx_r    <= 3'd7;
      shift_r       <= 8'h00;
      par_en_r      <= 1'b0;
      par_bit_r     <= 1'b0;
      stop2_r       <= 1'b0;
      stop_second_r <= 1'b0;
      hold_r        <= 8'h00;
      hold_full_r   <= 1'b0;
      serial_r      <= 1'b1;
      active_r      <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      idx_r         <= idx_s;
      last_idx_r    <= last_idx_s;
      shift_r       <= shift_s;
      par_en_r      <= par_en_s;
      par_bit_r     <= par_bit_s;
      stop2_r       <= stop2_s;
      stop_second_r <= stop_second_s;
      hold_r        <= hold_s;
      hold_full_r   <= hold_full_s;
      serial_r      <= serial_s;
      active_r      <= active_s;
      done_r        <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus pushes hand-written line
// patterns, a negedge monitor captures each frame and compares on o_TX_Done.
module tb_uart_tx_cfg;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_cfg_if bus();

  uart_tx_cfg #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  // seq holds the bit levels in time order: seq[n-1] is the start bit.
  typedef struct {
    logic [11:0] seq;
    int          n;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [63:0] cap;
  int          ncap = 0;
  logic        prev_done = 1'b0;
  exp_t        mon_e;
  logic        mon_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input logic [11:0] seq, input int n);
    exp_t e;
    e.seq = seq;
    e.n   = n;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.i_TX_DV   = 1'b1;
    bus.i_TX_Byte = b;
    @(negedge clk);
    bus.i_TX_DV   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.o_TX_Empty && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
  endtask

  // Monitor: capture line levels while active, check each frame on Done.
  always @(negedge clk) begin
    if (!rst_n) begin
      ncap      = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.o_TX_Done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width actual=2+_cycles required=1_cycle");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected actual=%0d_clocks required=no_frame", ncap);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_bad = 1'b0;
          if (ncap != mon_e.n * CPB) begin
            mon_bad = 1'b1;
          end else begin
            for (int t = 0; t < ncap; t++) begin
              if (cap[t] !== mon_e.seq[mon_e.n - 1 - t / CPB]) mon_bad = 1'b1;
            end
          end
          if (mon_bad) begin
            errors++;
            $display("FAIL frame_pattern actual_len=%0d actual_levels=%0h required_len=%0d required_bits=%0b",
                     ncap, cap, mon_e.n * CPB, mon_e.seq);
          end
        end
        ncap = 0;
      end
      if (bus.o_TX_Active && ncap < 64) begin
        cap[ncap] = bus.o_TX_Serial;
        ncap++;
      end
      prev_done = bus.o_TX_Done;
    end
  end

  initial begin
    bit found;
    bit idle_ok;
    rst_n             = 1'b0;
    bus.i_TX_DV       = 1'b0;
    bus.i_TX_Byte     = 8'h00;
    bus.i_Data_Bits   = 2'b11;
    bus.i_Parity_Mode = 2'b00;
    bus.i_Stop_Bits   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_serial", {31'd0, bus.o_TX_Serial}, 32'd1);
    chk("rst_active", {31'd0, bus.o_TX_Active}, 32'd0);
    chk("rst_done",   {31'd0, bus.o_TX_Done},   32'd0);
    chk("rst_ready",  {31'd0, bus.o_TX_Ready},  32'd1);
    chk("rst_empty",  {31'd0, bus.o_TX_Empty},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    expect_frame(12'b0101001011, 10);
    send(8'hA5);
    chk("accept_ready",  {31'd0, bus.o_TX_Ready},  32'd0);
    chk("accept_active", {31'd0, bus.o_TX_Active}, 32'd0);
    chk("accept_empty",  {31'd0, bus.o_TX_Empty},  32'd0);
    chk("accept_serial", {31'd0, bus.o_TX_Serial}, 32'd1);
    @(negedge clk);
    chk("start_serial", {31'd0, bus.o_TX_Serial}, 32'd0);
    chk("start_active", {31'd0, bus.o_TX_Active}, 32'd1);
    chk("start_ready",  {31'd0, bus.o_TX_Ready},  32'd1);
    wait_idle("a5");
    chk("a5_empty", {31'd0, bus.o_TX_Empty}, 32'd1);

    // 7 bits even, 0xFF: start, 7 ones, parity 1, stop
    bus.i_Data_Bits   = 2'b10;
    bus.i_Parity_Mode = 2'b01;
    expect_frame(12'b0111111111, 10);
    send(8'hFF);
    wait_idle("7e1");

    // 7 bits odd, 0xFF: parity 0
    bus.i_Parity_Mode = 2'b10;
    expect_frame(12'b0111111101, 10);
    send(8'hFF);
    wait_idle("7o1");

    // 5 bits force-1, 0x00
    bus.i_Data_Bits   = 2'b00;
    bus.i_Parity_Mode = 2'b11;
    expect_frame(12'b000000000011, 8);
    send(8'h00);
    wait_idle("5m1");

    // 6 bits, no parity, 2 stop, 0x15: 0,1,0,1,0,1,0,1,1 (36 clocks)
    bus.i_Data_Bits   = 2'b01;
    bus.i_Parity_Mode = 2'b00;
    bus.i_Stop_Bits   = 1'b1;
    expect_frame(12'b000010101011, 9);
    send(8'h15);
    wait_idle("6n2");

    // Back-to-back 0x55 then 0x33; third write 0x0F dropped
    bus.i_Data_Bits = 2'b11;
    bus.i_Stop_Bits = 1'b0;
    expect_frame(12'b000101010101, 10);
    expect_frame(12'b000110011001, 10);
    send(8'h55);
    repeat (8) @(negedge clk);
    send(8'h33);
    chk("b2b_ready_full", {31'd0, bus.o_TX_Ready}, 32'd0);
    repeat (2) @(negedge clk);
    bus.i_TX_DV   = 1'b1;
    bus.i_TX_Byte = 8'h0F;
    @(negedge clk);
    bus.i_TX_DV   = 1'b0;
    chk("drop_ready", {31'd0, bus.o_TX_Ready}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_TX_Done) begin
        found = 1'b1;
        break;
      end
      if (bus.o_TX_Ready) begin
        checks++;
        errors++;
        $display("FAIL b2b_ready_early actual=1 required=0");
        break;
      end
    end
    chk("b2b_done_seen", {31'd0, found}, 32'd1);
    chk("b2b_gap_serial", {31'd0, bus.o_TX_Serial}, 32'd0);
    chk("b2b_gap_active", {31'd0, bus.o_TX_Active}, 32'd1);
    chk("b2b_reload_ready", {31'd0, bus.o_TX_Ready}, 32'd1);
    wait_idle("b2b");
    repeat (12) @(negedge clk);

    // Config change mid-frame: 0xC3 keeps 8 bits, 0x1A goes out as 5 bits
    expect_frame(12'b000110000111, 10);
    send(8'hC3);
    repeat (2) @(negedge clk);
    bus.i_Data_Bits = 2'b00;
    expect_frame(12'b000000010111, 7);
    send(8'h1A);
    wait_idle("cfgchg");
    bus.i_Data_Bits = 2'b11;

    // Reset during DATA with a character also waiting in the holding register
    send(8'h81);
    send(8'h7E);
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_serial", {31'd0, bus.o_TX_Serial}, 32'd1);
    chk("mid_rst_active", {31'd0, bus.o_TX_Active}, 32'd0);
    chk("mid_rst_ready",  {31'd0, bus.o_TX_Ready},  32'd1);
    chk("mid_rst_empty",  {31'd0, bus.o_TX_Empty},  32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.o_TX_Serial !== 1'b1 || bus.o_TX_Active !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle_after_reset", {31'd0, idle_ok}, 32'd1);

    // Recovery frame 0x5A 8N1: 0,0,1,0,1,1,0,1,0,1
    expect_frame(12'b0010110101, 10);
    send(8'h5A);
    wait_idle("recover");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
